data_mem_responder: RTL

//  Data-memory end of the CPU load/store interface: accepts requests from

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_array.sv | 30 +++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the CPU data-memory responder: FSM state
// encoding, default widths and the wait-state counter limits.
package data_mem_responder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter preload for a WAIT phase of ws cycles, clamped to the supported range.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int ws);
    if (ws <= 0)
      return '0;
    else if (ws > WAIT_MAX)
      return WAIT_CNT_W'(WAIT_MAX - 1);
    else
      return WAIT_CNT_W'(ws - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous RAM: registered read, write-enable, no reset on contents.
module data_mem_responder_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data is only refreshed by a read access, so it holds through WAIT.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU-side data memory: accepts a load/store on cpu_req, waits WAIT_STATES
// cycles, then answers with a one-cycle cpu_ready pulse (plus cpu_err if out of range).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [DATA_W-1:0] data_mem_to_cpu
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  inrng_q, inrng_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic                  req_in_range;
  logic                  ram_en, ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

  assign req_in_range = int'(cpu_addr) < DEPTH;

  // The load read is launched at the accept edge so the RAM's registered
  // output is already settled by the time RESP samples it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    inrng_d  = inrng_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = AW'(addr_q);

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d     = cpu_we;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          inrng_d  = req_in_range;
          cnt_d    = WAIT_LOAD;
          state_d  = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          ram_addr = AW'(cpu_addr);
          ram_en   = req_in_range && !cpu_we;
        end
      end
      ST_WAIT: begin
        if (!cpu_req)
          state_d = ST_IDLE;
        else if (cnt_q == '0)
          state_d = ST_RESP;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        err_d   = !inrng_q;
        data_d  = (we_q || !inrng_q) ? '0 : ram_rdata;
        ram_en  = inrng_q && we_q;
        ram_we  = we_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // A store whose RESP edge coincides with reset must not commit.
    if (!rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    inrng_q <= inrng_d;
  end

  data_mem_responder_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign cpu_ready       = ready_q;
  assign cpu_err         = err_q;
  assign data_mem_to_cpu = data_q;

endmodule
